fpdiv_seq: RTL and testbench

FPDIV_SEQ -- requirements
Module: fpdiv_seq

---
 rtl/fpdiv_seq.sv | 102 ++++++++++
 tb/tb_fpdiv_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fpdiv_seq.sv
// Sequential sign-magnitude fixed-point divider: radix-2 restoring division,
// one quotient bit per cycle, with saturation and divide-by-zero flagging.
module fpdiv_seq #(
    parameter int N = 32,
    parameter int Q = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] c,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic         dz
);
    localparam int ITER = N - 1 + Q;
    localparam int CW   = $clog2(N + Q);
    localparam logic [CW-1:0] LAST = CW'(ITER);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state;
    logic [ITER-1:0] dvd;    // dividend shifts out the top, quotient bits shift in
    logic [N-2:0]    dvs;
    logic [N-2:0]    rem;
    logic            sgn;
    logic [CW-1:0]   cnt;

    logic [N-1:0]    trial;
    logic            ge;
    logic [N-2:0]    rem_nxt;
    logic            d_zero;
    logic            q_ovf;
    logic [N-2:0]    mag;

    always_comb begin
        trial   = {rem, dvd[ITER-1]};
        ge      = (trial >= {1'b0, dvs});
        // remainder stays below dvs, so the subtraction fits in N-1 bits
        rem_nxt = ge ? (trial[N-2:0] - dvs) : trial[N-2:0];
        d_zero  = (dvs == '0);
        q_ovf   = |dvd[ITER-1:N-1];
        mag     = (d_zero || q_ovf) ? '1 : dvd[N-2:0];
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            sgn   <= 1'b0;
            cnt   <= '0;
            c     <= '0;
            done  <= 1'b0;
            ovf   <= 1'b0;
            dz    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd   <= {a[N-2:0], {Q{1'b0}}};
                        dvs   <= b[N-2:0];
                        rem   <= '0;
                        sgn   <= a[N-1] ^ b[N-1];
                        cnt   <= '0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (cnt == LAST) begin
                        // zero magnitude never carries a sign
                        c     <= {sgn & (|mag), mag};
                        ovf   <= q_ovf & ~d_zero;
                        dz    <= d_zero;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        dvd <= {dvd[ITER-2:0], ge};
                        rem <= rem_nxt;
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpdiv_seq.sv
// Bench for fpdiv_seq: table vectors plus random ops through a scoreboard,
// and hand-written sequences for held start, back-to-back issue and reset abort.
module tb_fpdiv_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] c;
    logic        busy, done, ovf, dz;

    fpdiv_seq #(.N(32), .Q(15)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .c(c), .busy(busy), .done(done), .ovf(ovf), .dz(dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        ovf;
        logic        dz;
    } vec_t;

    typedef struct {
        logic [31:0] c;
        logic        ovf;
        logic        dz;
        int unsigned t0;
    } exp_t;

    exp_t        sbq[$];
    vec_t        tbl[12];
    int          n_pass = 0;
    int          n_chk  = 0;
    int          n_done = 0;
    int unsigned cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, want);
    endtask

    function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib);
        exp_t        r;
        logic [63:0] num, q;
        logic [30:0] m;
        num   = {33'd0, ia[30:0]} << 15;
        r.ovf = 1'b0;
        r.dz  = 1'b0;
        r.t0  = 0;
        if (ib[30:0] == 31'd0) begin
            r.dz = 1'b1;
            m    = '1;
        end else begin
            q = num / {33'd0, ib[30:0]};
            if (q > 64'h7FFF_FFFF) begin
                r.ovf = 1'b1;
                m     = '1;
            end else begin
                m = q[30:0];
            end
        end
        r.c = {(ia[31] ^ ib[31]) & (m != 31'd0), m};
        return r;
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            n_done++;
            if (sbq.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_done: got done=1 expected no pending op at cyc %0d", cyc);
            end else begin
                e = sbq.pop_front();
                chk("c", {32'd0, c}, {32'd0, e.c});
                chk("ovf", {63'd0, ovf}, {63'd0, e.ovf});
                chk("dz", {63'd0, dz}, {63'd0, e.dz});
                chk("latency", 64'(cyc - e.t0), 64'd47);
            end
        end
    end

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input exp_t e);
        @(negedge clk);
        a     = ia;
        b     = ib;
        start = 1'b1;
        e.t0  = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 200; i++) begin
            if (n_done >= target) return;
            @(posedge clk);
            #2;
        end
        n_chk++;
        $display("FAIL done_timeout: got %0d dones expected %0d", n_done, target);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   tgt;
        e.c   = v.c;
        e.ovf = v.ovf;
        e.dz  = v.dz;
        e.t0  = 0;
        tgt   = n_done + 1;
        issue(v.a, v.b, e);
        wait_done(tgt);
    endtask

    initial begin
        exp_t e;
        vec_t v;
        int   tgt;
        logic got;

        tbl[0]  = '{32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0, 1'b0};
        tbl[1]  = '{32'h8000_8000, 32'h0002_0000, 32'h8000_2000, 1'b0, 1'b0};
        tbl[2]  = '{32'h8000_0000, 32'h0000_8000, 32'h0000_0000, 1'b0, 1'b0};
        tbl[3]  = '{32'h7FFF_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0};
        tbl[4]  = '{32'h0000_8000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1};
        tbl[5]  = '{32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 1'b0, 1'b0};
        tbl[6]  = '{32'h8001_0000, 32'h8000_8000, 32'h0001_0000, 1'b0, 1'b0};
        tbl[7]  = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
        tbl[8]  = '{32'h0001_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0};
        tbl[9]  = '{32'h8000_FFFF, 32'h0000_0001, 32'hFFFF_8000, 1'b0, 1'b0};
        tbl[10] = '{32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
        tbl[11] = '{32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_c", {32'd0, c}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        chk("rst_dz", {63'd0, dz}, 64'd0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(tbl[i]);

        repeat (5) @(negedge clk);
        chk("c_hold", {32'd0, c}, {32'd0, tbl[11].c});

        for (int i = 0; i < 8; i++) begin
            v.a   = $urandom & 32'h800F_FFFF;
            v.b   = $urandom & 32'h8003_FFFF;
            e     = model(v.a, v.b);
            v.c   = e.c;
            v.ovf = e.ovf;
            v.dz  = e.dz;
            run_vec(v);
        end

        // start held high with operands wandering during CALC, then re-issue right after done
        tgt = n_done + 2;
        @(negedge clk);
        a     = 32'h0001_8000;
        b     = 32'h0001_0000;
        start = 1'b1;
        e     = '{32'h0000_C000, 1'b0, 1'b0, cyc + 1};
        sbq.push_back(e);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
        end
        chk("busy_calc", {63'd0, busy}, 64'd1);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) got = 1'b1;
        end
        chk("held_start_done_seen", {63'd0, got}, 64'd1);
        a = 32'h8000_8000;
        b = 32'h0002_0000;
        @(negedge clk);
        e = '{32'h8000_2000, 1'b0, 1'b0, cyc + 1};
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_done(tgt);

        // reset in the middle of CALC abandons the op
        tgt = n_done;
        e   = model(32'h0001_8000, 32'h0001_0000);
        issue(32'h0001_8000, 32'h0001_0000, e);
        repeat (19) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_c", {32'd0, c}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_ovf", {63'd0, ovf}, 64'd0);
        chk("midrst_dz", {63'd0, dz}, 64'd0);
        sbq.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        chk("midrst_no_done", 64'(n_done), 64'(tgt));
        run_vec(tbl[1]);
        run_vec(tbl[3]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
